// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM with key debounce and lap snapshot; optional auto-stop via STOPWATCH_AUTOSTOP_EN
module stopwatch_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] MAX_COUNT       = 16'hFFFF
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        key_ss_n,
  input  logic        key_lap_n,
  input  logic        tick,
  input  logic [15:0] count_in,
  output logic        count_en,
  output logic        count_clr,
  output logic [15:0] disp_value,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_LAP
  } state_t;

  // Bit 0 of every per-key vector is start/stop, bit 1 is lap/clear.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         db_lvl_q, db_lvl_d;
  logic [1:0][CW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         press_q, press_d;

  state_t      state_q, state_d;
  logic [15:0] lap_q, lap_d;
  logic [15:0] disp_q, disp_d;
  logic        clr_q, clr_d;
  logic        ovf_q, ovf_d;

  logic press_ss;
  logic press_lap;
  logic at_max;

  assign press_ss  = press_q[0];
  assign press_lap = press_q[1];

  assign running    = (state_q == S_RUN) || (state_q == S_LAP);
  assign lap_active = (state_q == S_LAP);
  assign count_en   = tick && running && !at_max;
  assign count_clr  = clr_q;
  assign disp_value = disp_q;

`ifdef STOPWATCH_AUTOSTOP_EN
  assign at_max   = running && (count_in == MAX_COUNT);
  assign overflow = ovf_q;
`else
  logic unused_max;
  assign at_max     = 1'b0;
  assign overflow   = 1'b0;
  assign unused_max = ^MAX_COUNT;
`endif

  // Synchronize both keys, then flip the debounced level after a full run of
  // stable mismatching samples; a flip to pressed (low) emits a one-cycle pulse.
  always_comb begin
    sync1_d  = {key_lap_n, key_ss_n};
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    press_d  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != db_lvl_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          db_lvl_d[k] = sync2_q[k];
          db_cnt_d[k] = '0;
          press_d[k]  = ~sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

  // Next state; start/stop wins over lap when both pulse in the same cycle.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    ovf_d   = ovf_q;
    disp_d  = (state_q == S_LAP) ? lap_q : count_in;
    case (state_q)
      S_IDLE: begin
        if (press_ss) begin
          state_d = S_RUN;
        end else if (press_lap) begin
          clr_d = 1'b1;
        end
      end
      S_RUN: begin
        if (at_max) begin
          state_d = S_PAUSED;
          ovf_d   = 1'b1;
        end else if (press_ss) begin
          state_d = S_PAUSED;
        end else if (press_lap) begin
          state_d = S_LAP;
          lap_d   = count_in;
        end
      end
      S_LAP: begin
        if (at_max) begin
          state_d = S_PAUSED;
          ovf_d   = 1'b1;
        end else if (press_ss) begin
          state_d = S_PAUSED;
        end else if (press_lap) begin
          state_d = S_RUN;
        end
      end
      S_PAUSED: begin
        if (press_ss) begin
          if (!ovf_q) begin
            state_d = S_RUN;
          end
        end else if (press_lap) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_IDLE) begin
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers; reset drops everything back to IDLE at once.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      db_lvl_q <= 2'b11;
      db_cnt_q <= '0;
      press_q  <= 2'b00;
      state_q  <= S_IDLE;
      lap_q    <= '0;
      disp_q   <= '0;
      clr_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_lvl_q <= db_lvl_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      state_q  <= state_d;
      lap_q    <= lap_d;
      disp_q   <= disp_d;
      clr_q    <= clr_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with a behavioural 16-bit counter
module tb_stopwatch_ctrl;

  logic        CLOCK_50  = 1'b0;
  logic        reset_n   = 1'b0;
  logic        key_ss_n  = 1'b1;
  logic        key_lap_n = 1'b1;
  logic        tick      = 1'b0;
  logic [15:0] count_in  = 16'd0;
  logic        count_en;
  logic        count_clr;
  logic [15:0] disp_value;
  logic        running;
  logic        lap_active;
  logic        overflow;

  logic        load_req = 1'b0;
  logic [15:0] load_val = 16'd0;

  int checks   = 0;
  int failures = 0;
  int exp_clr  = 0;
  int clr_seen = 0;

  int          sig_q[$];
  logic [15:0] val_q[$];
  string       name_q[$];

  localparam int SIG_RUN = 0, SIG_LAP = 1, SIG_EN = 2, SIG_CLR = 3, SIG_DISP = 4, SIG_OVF = 5, SIG_NCLR = 6;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MAX_COUNT(16'd20)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n(reset_n),
    .key_ss_n(key_ss_n),
    .key_lap_n(key_lap_n),
    .tick(tick),
    .count_in(count_in),
    .count_en(count_en),
    .count_clr(count_clr),
    .disp_value(disp_value),
    .running(running),
    .lap_active(lap_active),
    .overflow(overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (load_req) count_in <= load_val;
    else if (count_clr) count_in <= 16'd0;
    else if (count_en) count_in <= count_in + 16'd1;
  end

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      SIG_RUN:  return {15'd0, running};
      SIG_LAP:  return {15'd0, lap_active};
      SIG_EN:   return {15'd0, count_en};
      SIG_CLR:  return {15'd0, count_clr};
      SIG_DISP: return disp_value;
      SIG_OVF:  return {15'd0, overflow};
      default:  return clr_seen[15:0];
    endcase
  endfunction

  always @(negedge CLOCK_50) begin
    int          s;
    logic [15:0] v;
    logic [15:0] act;
    string       n;
    while (sig_q.size() > 0) begin
      s   = sig_q.pop_front();
      v   = val_q.pop_front();
      n   = name_q.pop_front();
      act = observe(s);
      checks++;
      if (act !== v) begin
        failures++;
        $display("FAIL %s actual=%0d expected=%0d", n, act, v);
      end
    end
    checks++;
    if (count_clr && count_en) begin
      failures++;
      $display("FAIL clr_en_overlap actual=1 expected=0");
    end
    if (count_clr) clr_seen++;
  end

  task automatic expect_sig(input int sig, input logic [15:0] val, input string name);
    sig_q.push_back(sig);
    val_q.push_back(val);
    name_q.push_back(name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic keys(input logic ss, input logic lap);
    key_ss_n  = ~ss;
    key_lap_n = ~lap;
  endtask

  task automatic press(input logic ss, input logic lap);
    keys(ss, lap);
    step(7);
  endtask

  task automatic release_keys();
    keys(1'b0, 1'b0);
    step(8);
  endtask

  task automatic load(input logic [15:0] v);
    load_req = 1'b1;
    load_val = v;
    step(1);
    load_req = 1'b0;
  endtask

  initial begin
    bit drained;
    step(2);
    expect_sig(SIG_RUN, 0, "reset_running");
    expect_sig(SIG_LAP, 0, "reset_lap");
    expect_sig(SIG_EN, 0, "reset_en");
    expect_sig(SIG_CLR, 0, "reset_clr");
    expect_sig(SIG_DISP, 0, "reset_disp");
    expect_sig(SIG_OVF, 0, "reset_ovf");
    step(1);
    reset_n = 1'b1;
    step(2);

    keys(1'b1, 1'b0);
    step(3);
    keys(1'b0, 1'b0);
    tick = 1'b1;
    step(8);
    expect_sig(SIG_RUN, 0, "glitch_idle");
    expect_sig(SIG_EN, 0, "glitch_en");
    tick = 1'b0;
    step(1);

    keys(1'b1, 1'b0);
    step(6);
    expect_sig(SIG_RUN, 0, "latency_c6_idle");
    step(1);
    expect_sig(SIG_RUN, 1, "latency_c7_run");
    expect_sig(SIG_LAP, 0, "run_not_lap");
    tick = 1'b1;
    expect_sig(SIG_EN, 1, "run_en_tick1");
    step(1);
    tick = 1'b0;
    expect_sig(SIG_EN, 0, "run_en_tick0");
    release_keys();

    load(16'd1234);
    step(1);
    expect_sig(SIG_DISP, 16'd1234, "disp_live_1234");
    press(1'b0, 1'b1);
    expect_sig(SIG_LAP, 1, "lap_entered");
    expect_sig(SIG_RUN, 1, "lap_running");
    tick = 1'b1;
    expect_sig(SIG_EN, 1, "lap_en_tick1");
    step(6);
    tick = 1'b0;
    expect_sig(SIG_DISP, 16'd1234, "lap_disp_frozen");
    expect_sig(SIG_EN, 0, "lap_en_tick0");
    release_keys();
    press(1'b0, 1'b1);
    expect_sig(SIG_LAP, 0, "lap_left");
    expect_sig(SIG_RUN, 1, "lap_back_run");
    step(1);
    expect_sig(SIG_DISP, 16'd1240, "disp_resume_1240");
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    expect_sig(SIG_DISP, 16'd1240, "disp_lag_1240");
    step(1);
    expect_sig(SIG_DISP, 16'd1241, "disp_lag_1241");
    release_keys();

    press(1'b1, 1'b0);
    expect_sig(SIG_RUN, 0, "paused_not_running");
    tick = 1'b1;
    expect_sig(SIG_EN, 0, "paused_en_0");
    step(1);
    tick = 1'b0;
    release_keys();
    press(1'b0, 1'b1);
    exp_clr++;
    expect_sig(SIG_CLR, 1, "pause_clr_pulse");
    expect_sig(SIG_RUN, 0, "pause_to_idle");
    step(1);
    expect_sig(SIG_CLR, 0, "pause_clr_single");
    step(1);
    expect_sig(SIG_DISP, 0, "disp_after_clear");
    release_keys();

    load(16'd55);
    press(1'b0, 1'b1);
    exp_clr++;
    expect_sig(SIG_CLR, 1, "idle_clr_pulse");
    expect_sig(SIG_RUN, 0, "idle_stays_idle");
    step(1);
    expect_sig(SIG_CLR, 0, "idle_clr_single");
    step(1);
    expect_sig(SIG_DISP, 0, "idle_disp_cleared");
    release_keys();

    press(1'b1, 1'b0);
    release_keys();
    load(16'd777);
    press(1'b1, 1'b1);
    expect_sig(SIG_RUN, 0, "both_paused");
    expect_sig(SIG_LAP, 0, "both_not_lap");
    step(1);
    expect_sig(SIG_DISP, 16'd777, "both_disp_live");
    release_keys();

    press(1'b1, 1'b0);
    release_keys();
    load(16'd18);
    tick = 1'b1;
    step(2);
`ifdef STOPWATCH_AUTOSTOP_EN
    expect_sig(SIG_EN, 0, "autostop_en_forced");
    expect_sig(SIG_RUN, 1, "autostop_still_run");
    expect_sig(SIG_OVF, 0, "autostop_ovf_pre");
    step(1);
    tick = 1'b0;
    expect_sig(SIG_RUN, 0, "autostop_paused");
    expect_sig(SIG_OVF, 1, "autostop_ovf_set");
    press(1'b1, 1'b0);
    expect_sig(SIG_RUN, 0, "autostop_ss_ignored");
    expect_sig(SIG_OVF, 1, "autostop_ovf_kept");
    release_keys();
    press(1'b0, 1'b1);
    exp_clr++;
    expect_sig(SIG_RUN, 0, "autostop_idle");
    expect_sig(SIG_OVF, 0, "autostop_ovf_clr");
    expect_sig(SIG_CLR, 1, "autostop_clr_pulse");
    release_keys();
`else
    expect_sig(SIG_EN, 1, "noauto_en_at_20");
    expect_sig(SIG_RUN, 1, "noauto_run_at_20");
    expect_sig(SIG_OVF, 0, "noauto_ovf_0");
    load(16'hFFFF);
    step(1);
    tick = 1'b0;
    expect_sig(SIG_RUN, 1, "wrap_still_run");
    expect_sig(SIG_OVF, 0, "wrap_ovf_0");
    step(1);
    expect_sig(SIG_DISP, 0, "wrap_disp_0");
    press(1'b1, 1'b0);
    release_keys();
    press(1'b0, 1'b1);
    exp_clr++;
    expect_sig(SIG_CLR, 1, "noauto_clr_pulse");
    release_keys();
`endif

    press(1'b1, 1'b0);
    release_keys();
    load(16'd300);
    tick = 1'b1;
    step(2);
    expect_sig(SIG_EN, 1, "prereset_en");
    step(1);
    keys(1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    expect_sig(SIG_EN, 0, "midreset_en");
    expect_sig(SIG_RUN, 0, "midreset_running");
    expect_sig(SIG_DISP, 0, "midreset_disp");
    expect_sig(SIG_CLR, 0, "midreset_clr");
    expect_sig(SIG_OVF, 0, "midreset_ovf");
    step(3);
    tick = 1'b0;
    reset_n = 1'b1;
    step(2);
    expect_sig(SIG_RUN, 0, "release_no_press");
    keys(1'b0, 1'b0);
    step(8);
    expect_sig(SIG_RUN, 0, "release_still_idle");
    expect_sig(SIG_NCLR, exp_clr[15:0], "clr_pulse_count");

    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (sig_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sig_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
